// File: rtl/flag_write_scheduler.sv
// Write-port sequencer for the valid-flag RAM: zero sweep after reset/clear,
// then round-robin service of insert (A) and delete (B) requesters.
module flag_write_scheduler #(
  parameter int SIZE        = 10,
  parameter int BUCKET_SIZE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_i,
  input  logic                   clear_req_i,
  input  logic                   a_valid_i,
  output logic                   a_ready_o,
  input  logic [SIZE-1:0]        a_adr_i,
  input  logic [BUCKET_SIZE-1:0] a_flags_i,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  input  logic [SIZE-1:0]        b_adr_i,
  input  logic [BUCKET_SIZE-1:0] b_flags_i,
  output logic                   write_en_o,
  output logic [SIZE-1:0]        write_adr_o,
  output logic [BUCKET_SIZE-1:0] write_is_valid_o,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic {SWEEP, SERVE} state_e;

  state_e                 state_q;
  logic [SIZE-1:0]        cnt_q;
  logic                   rr_q;
  logic                   wen_q;
  logic [SIZE-1:0]        wadr_q;
  logic [BUCKET_SIZE-1:0] wflg_q;
  logic                   done_q;

  logic grant_a;
  logic grant_b;
  logic serve_ok;

  // rr_q: 0 favours A, 1 favours B when both are valid
  always_comb begin
    grant_a  = a_valid_i & (~b_valid_i | ~rr_q);
    grant_b  = b_valid_i & (~a_valid_i | rr_q);
    serve_ok = (state_q == SERVE) & ~stall_i & ~clear_req_i;
  end

  assign a_ready_o        = serve_ok & grant_a;
  assign b_ready_o        = serve_ok & grant_b;
  assign busy_o           = (state_q == SWEEP);
  assign write_en_o       = wen_q;
  assign write_adr_o      = wadr_q;
  assign write_is_valid_o = wflg_q;
  assign done_o           = done_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      wen_q   <= 1'b0;
      wadr_q  <= '0;
      wflg_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      wen_q  <= 1'b0;
      done_q <= 1'b0;
      if (!stall_i) begin
        case (state_q)
          SWEEP: begin
            wen_q  <= 1'b1;
            wadr_q <= cnt_q;
            wflg_q <= '0;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == '1) begin
              done_q  <= 1'b1;
              state_q <= SERVE;
            end
          end
          SERVE: begin
            if (clear_req_i) begin
              state_q <= SWEEP;
              cnt_q   <= '0;
            end else if (a_valid_i && grant_a) begin
              wen_q  <= 1'b1;
              wadr_q <= a_adr_i;
              wflg_q <= a_flags_i;
              rr_q   <= 1'b1;
            end else if (b_valid_i && grant_b) begin
              wen_q  <= 1'b1;
              wadr_q <= b_adr_i;
              wflg_q <= b_flags_i;
              rr_q   <= 1'b0;
            end
          end
          default: state_q <= SWEEP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flag_write_scheduler.sv
// Directed bench for flag_write_scheduler with SIZE=3: vector table for
// arbitration plus hand sequences for sweep, stall, clear and reset.
module tb_flag_write_scheduler;

  localparam int SIZE = 3;
  localparam int BS   = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall_i, clear_req_i;
  logic            a_valid_i, b_valid_i;
  logic            a_ready_o, b_ready_o;
  logic [SIZE-1:0] a_adr_i, b_adr_i;
  logic [BS-1:0]   a_flags_i, b_flags_i;
  logic            write_en_o;
  logic [SIZE-1:0] write_adr_o;
  logic [BS-1:0]   write_is_valid_o;
  logic            busy_o, done_o;

  int errors = 0;
  int checks = 0;
  int wcount = 0;

  always #5 clk = ~clk;

  flag_write_scheduler #(.SIZE(SIZE), .BUCKET_SIZE(BS)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall_i          (stall_i),
    .clear_req_i      (clear_req_i),
    .a_valid_i        (a_valid_i),
    .a_ready_o        (a_ready_o),
    .a_adr_i          (a_adr_i),
    .a_flags_i        (a_flags_i),
    .b_valid_i        (b_valid_i),
    .b_ready_o        (b_ready_o),
    .b_adr_i          (b_adr_i),
    .b_flags_i        (b_flags_i),
    .write_en_o       (write_en_o),
    .write_adr_o      (write_adr_o),
    .write_is_valid_o (write_is_valid_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  typedef struct {
    bit       rst;
    bit       stall;
    bit       clr;
    bit       av;
    bit [2:0] aa;
    bit       af;
    bit       bv;
    bit [2:0] ba;
    bit       bf;
    bit       e_ar;
    bit       e_br;
    bit       e_busy;
    bit       e_wen;
    bit [2:0] e_wad;
    bit       e_wf;
    bit       e_done;
  } vec_t;

  function automatic vec_t mk(
    bit rst, bit stall, bit clr,
    bit av, bit [2:0] aa, bit af,
    bit bv, bit [2:0] ba, bit bf,
    bit ear, bit ebr, bit ebusy,
    bit ewen, bit [2:0] ewad, bit ewf, bit edone);
    vec_t v;
    v.rst = rst; v.stall = stall; v.clr = clr;
    v.av = av; v.aa = aa; v.af = af;
    v.bv = bv; v.ba = ba; v.bf = bf;
    v.e_ar = ear; v.e_br = ebr; v.e_busy = ebusy;
    v.e_wen = ewen; v.e_wad = ewad; v.e_wf = ewf;
    v.e_done = edone;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", n, act, exp);
    end
  endtask

  // Inputs drive after posedge; ready/busy checked at negedge,
  // registered write outputs checked just after the following posedge.
  task automatic apply(input vec_t v, input string nm);
    reset       = v.rst;
    stall_i     = v.stall;
    clear_req_i = v.clr;
    a_valid_i   = v.av;
    a_adr_i     = v.aa;
    a_flags_i   = v.af;
    b_valid_i   = v.bv;
    b_adr_i     = v.ba;
    b_flags_i   = v.bf;
    @(negedge clk);
    chk({nm, ".a_ready"}, 32'(a_ready_o), 32'(v.e_ar));
    chk({nm, ".b_ready"}, 32'(b_ready_o), 32'(v.e_br));
    chk({nm, ".busy"}, 32'(busy_o), 32'(v.e_busy));
    @(posedge clk);
    #1;
    if (write_en_o === 1'b1) wcount++;
    chk({nm, ".wen"}, 32'(write_en_o), 32'(v.e_wen));
    chk({nm, ".wadr"}, 32'(write_adr_o), 32'(v.e_wad));
    chk({nm, ".wflg"}, 32'(write_is_valid_o), 32'(v.e_wf));
    chk({nm, ".done"}, 32'(done_o), 32'(v.e_done));
  endtask

  task automatic sweep(input int from, input int to, input bit av,
                       input bit [2:0] aa, input bit af, input int clr_n,
                       input string nm);
    for (int k = from; k <= to; k++) begin
      apply(mk(1, 0, (k - from) < clr_n, av, aa, af, 0, 0, 0,
               0, 0, 1, 1, 3'(k), 0, k == 7),
            $sformatf("%s[%0d]", nm, k));
    end
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = mk(1,0,0, 1,5,1, 0,0,0, 1,0,0, 1,5,1,0);
    tbl[1]  = mk(1,0,0, 0,0,0, 0,0,0, 0,0,0, 0,5,1,0);
    tbl[2]  = mk(1,0,0, 0,0,0, 1,3,0, 0,1,0, 1,3,0,0);
    tbl[3]  = mk(1,0,0, 1,2,1, 1,6,0, 1,0,0, 1,2,1,0);
    tbl[4]  = mk(1,0,0, 1,2,1, 1,6,0, 0,1,0, 1,6,0,0);
    tbl[5]  = mk(1,0,0, 1,2,1, 1,6,0, 1,0,0, 1,2,1,0);
    tbl[6]  = mk(1,0,0, 1,2,1, 1,6,0, 0,1,0, 1,6,0,0);
    tbl[7]  = mk(1,0,0, 0,0,0, 0,0,0, 0,0,0, 0,6,0,0);
    tbl[8]  = mk(1,1,0, 1,4,1, 1,1,1, 0,0,0, 0,6,0,0);
    tbl[9]  = mk(1,0,0, 1,4,1, 1,1,1, 1,0,0, 1,4,1,0);
    tbl[10] = mk(1,0,0, 0,0,0, 1,1,1, 0,1,0, 1,1,1,0);
    tbl[11] = mk(1,0,0, 0,0,0, 0,0,0, 0,0,0, 0,1,1,0);

    reset = 0; stall_i = 0; clear_req_i = 0;
    a_valid_i = 1; a_adr_i = 5; a_flags_i = 1;
    b_valid_i = 0; b_adr_i = 0; b_flags_i = 0;
    @(posedge clk);
    #1;
    apply(mk(0,0,0, 1,5,1, 0,0,0, 0,0,1, 0,0,0,0), "rst_held");

    // initial sweep with A waiting: A granted only after done
    sweep(0, 7, 1, 5, 1, 0, "sweep0");
    for (int i = 0; i < 12; i++)
      apply(tbl[i], $sformatf("tbl%0d", i));

    // clear while A valid; clear held into sweep is ignored
    apply(mk(1,0,1, 1,7,1, 0,0,0, 0,0,0, 0,1,1,0), "clr");
    sweep(0, 7, 1, 7, 1, 3, "sweep_clr");
    apply(mk(1,0,0, 1,7,1, 0,0,0, 1,0,0, 1,7,1,0), "after_clr");

    // stall for 3 cycles at sweep address 4
    apply(mk(1,0,1, 0,0,0, 0,0,0, 0,0,0, 0,7,1,0), "clr2");
    wcount = 0;
    sweep(0, 3, 0, 0, 0, 0, "sweep_st");
    for (int i = 0; i < 3; i++)
      apply(mk(1,1,0, 0,0,0, 0,0,0, 0,0,1, 0,3,0,0),
            $sformatf("stall%0d", i));
    sweep(4, 7, 0, 0, 0, 0, "sweep_st");
    chk("stall_sweep_writes", 32'(wcount), 32'd8);

    // reset at sweep address 5 restarts the full sweep
    apply(mk(1,0,1, 0,0,0, 0,0,0, 0,0,0, 0,7,0,0), "clr3");
    sweep(0, 4, 0, 0, 0, 0, "sweep_rs");
    apply(mk(0,0,0, 0,0,0, 0,0,0, 0,0,1, 0,0,0,0), "rst_mid");
    wcount = 0;
    sweep(0, 7, 0, 0, 0, 0, "sweep_rs2");
    chk("rst_sweep_writes", 32'(wcount), 32'd8);

    // reset coinciding with a handshake drops the write
    apply(mk(0,0,0, 1,2,1, 0,0,0, 1,0,0, 0,0,0,0), "rst_serve");
    apply(mk(1,0,0, 0,0,0, 0,0,0, 0,0,1, 1,0,0,0), "resweep");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
